// File: rtl/stepper_motor_ctrl.sv
// stepper_motor_ctrl: step sequencer with wave/full/half modes, divider and position count; STEPPER_MOTOR_CTRL_HOLD_EN keeps coils energised when idle
module stepper_motor_ctrl #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 24
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [1:0]              cmd_mode,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [DIV_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic [3:0]              coils,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                     4'b0010, 4'b0011, 4'b0001, 4'b1001};
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d, per_q, per_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d, dir_q, dir_d, half_q, half_d;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
  logic             en_q, en_d;
`endif
  // next state: accept in IDLE, count down the divider and step in RUN, abort wins over a step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    per_d   = per_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    half_d  = half_q;
    done_d  = 1'b0;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
    en_d    = en_q;
`endif
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        idx_d  = cmd_mode == 2'b10 ? idx_q : {idx_q[2:1], cmd_mode[0]};
        half_d = cmd_mode == 2'b10;
        dir_d  = cmd_dir;
        rem_d  = cmd_steps;
        per_d  = cmd_period == '0 ? '0 : cmd_period - DIV_W'(1);
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
        en_d   = 1'b1;
`endif
        if (cmd_steps != '0) begin
          state_d = RUN;
          div_d   = per_d;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (abort) begin
      state_d = IDLE;
    end else if (div_q != '0) begin
      div_d = div_q - DIV_W'(1);
    end else begin
      idx_d = idx_q + (dir_q ? (half_q ? 3'd1 : 3'd2) : (half_q ? 3'd7 : 3'd6));
      pos_d = pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
      rem_d = rem_q - CNT_W'(1);
      div_d = per_q;
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  // state register with synchronous reset
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
      en_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      done_q  <= done_d;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
      en_q    <= en_d;
`endif
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q == RUN;
  assign done      = done_q;
  assign position  = pos_q;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
  assign coils = (state_q == RUN || en_q) ? TBL[idx_q] : 4'b0000;
`else
  assign coils = state_q == RUN ? TBL[idx_q] : 4'b0000;
`endif
endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// tb_stepper_motor_ctrl: directed scoreboard bench for stepper_motor_ctrl
module tb_stepper_motor_ctrl;
`ifdef STEPPER_MOTOR_CTRL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic               system1000 = 1'b0, system1000_rst = 1'b1;
  logic               cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, abort = 1'b0;
  logic [1:0]         cmd_mode = 2'b00;
  logic [15:0]        cmd_steps = '0, cmd_period = '0;
  logic [3:0]         coils;
  logic               busy, done;
  logic signed [23:0] position;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic b; logic d; logic [3:0] c; logic [23:0] p;} exp_t;
  exp_t sb[$];

  stepper_motor_ctrl dut (
    .system1000(system1000), .system1000_rst(system1000_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_mode(cmd_mode), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .coils(coils), .busy(busy), .done(done), .position(position)
  );

  always #5 system1000 = ~system1000;

  function automatic logic [3:0] ic(input logic [3:0] c);
    return HOLD ? c : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic b, input logic d, input logic [3:0] c, input logic [23:0] p);
    exp_t e;
    e.tag = tag; e.b = b; e.d = d; e.c = c; e.p = p;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge system1000);
    #1;
  endtask

  task automatic send(input logic dir, input logic [1:0] mode, input logic [15:0] steps, input logic [15:0] per);
    cmd_dir = dir; cmd_mode = mode; cmd_steps = steps; cmd_period = per; cmd_valid = 1'b1;
  endtask

  task automatic run(input int n, input int abort_at);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) abort = 1'b1;
      tick();
      cmd_valid = 1'b0;
      abort = 1'b0;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_busy"}, 32'(busy), 32'(e.b));
        chk({e.tag, "_done"}, 32'(done), 32'(e.d));
        chk({e.tag, "_coils"}, 32'(coils), 32'(e.c));
        chk({e.tag, "_pos"}, 32'(position), 32'(e.p));
      end
    end
  endtask

  initial begin
    tick();
    tick();
    system1000_rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_coils", 32'(coils), 0);
    chk("rst_pos", 32'(position), 0);
    // half forward, 3 steps, period 2
    send(1'b1, 2'b10, 16'd3, 16'd2);
    push("half0", 1, 0, 4'b1000, 0);
    push("half1", 1, 0, 4'b1000, 0);
    push("half2", 1, 0, 4'b1100, 1);
    push("half3", 1, 0, 4'b1100, 1);
    push("half4", 1, 0, 4'b0100, 2);
    push("half5", 1, 0, 4'b0100, 2);
    push("half6", 0, 1, ic(4'b0110), 3);
    push("half7", 0, 0, ic(4'b0110), 3);
    run(8, -1);
    chk("half_ready", 32'(cmd_ready), 1);
    // wave reverse from idx 3: aligned to idx 2, then 0, then 6
    send(1'b0, 2'b00, 16'd2, 16'd1);
    push("wave0", 1, 0, 4'b0100, 3);
    push("wave1", 1, 0, 4'b1000, 2);
    push("wave2", 0, 1, ic(4'b0001), 1);
    push("wave3", 0, 0, ic(4'b0001), 1);
    run(4, -1);
    // full forward, period 0 acts as 1
    send(1'b1, 2'b01, 16'd4, 16'd0);
    push("full0", 1, 0, 4'b1001, 1);
    push("full1", 1, 0, 4'b1100, 2);
    push("full2", 1, 0, 4'b0110, 3);
    push("full3", 1, 0, 4'b0011, 4);
    push("full4", 0, 1, ic(4'b1001), 5);
    push("full5", 0, 0, ic(4'b1001), 5);
    run(6, -1);
    // zero steps: done only
    send(1'b1, 2'b10, 16'd0, 16'd5);
    push("zero0", 0, 1, ic(4'b1001), 5);
    push("zero1", 0, 0, ic(4'b1001), 5);
    run(2, -1);
    chk("zero_ready", 32'(cmd_ready), 1);
    // mode 11 behaves as full; abort on final step edge
    send(1'b1, 2'b11, 16'd5, 16'd2);
    push("ab0", 1, 0, 4'b1001, 5);
    push("ab1", 1, 0, 4'b1001, 5);
    push("ab2", 1, 0, 4'b1100, 6);
    push("ab3", 1, 0, 4'b1100, 6);
    push("ab4", 1, 0, 4'b0110, 7);
    push("ab5", 1, 0, 4'b0110, 7);
    push("ab6", 1, 0, 4'b0011, 8);
    push("ab7", 1, 0, 4'b0011, 8);
    push("ab8", 1, 0, 4'b1001, 9);
    push("ab9", 1, 0, 4'b1001, 9);
    push("ab10", 0, 0, ic(4'b1001), 9);
    push("ab11", 0, 0, ic(4'b1001), 9);
    run(12, 10);
    chk("ab_ready", 32'(cmd_ready), 1);
    // abort in idle has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", 32'(cmd_ready), 1);
    chk("idle_abort_pos", 32'(position), 9);
    // half reverse, reset mid-move
    send(1'b0, 2'b10, 16'd10, 16'd1);
    push("mid0", 1, 0, 4'b1001, 9);
    push("mid1", 1, 0, 4'b0001, 8);
    push("mid2", 1, 0, 4'b0011, 7);
    run(3, -1);
    system1000_rst = 1'b1;
    tick();
    system1000_rst = 1'b0;
    chk("mrst_ready", 32'(cmd_ready), 1);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_coils", 32'(coils), 0);
    chk("mrst_pos", 32'(position), 0);
    tick();
    chk("mrst_done_after", 32'(done), 0);
    chk("mrst_busy_after", 32'(busy), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
